// File: rtl/stream_demux12.sv
// rtl/stream_demux12.sv - 1-to-2 packet stream demultiplexer with per-output register stage
//
// Optional feature macro: DEMUX_PKT_CNT_EN (adds pkt_cnt0/pkt_cnt1 packet counters)
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   s_data, s_valid, s_last, s_ready  input stream (s_ready out)
//   sel                             destination select, sampled on first beat of a packet
//   m0_data, m0_valid, m0_last, m0_ready  output stream 0 (m0_ready in)
//   m1_data, m1_valid, m1_last, m1_ready  output stream 1 (m1_ready in)
//   pkt_cnt0, pkt_cnt1              packets routed to m0/m1 (DEMUX_PKT_CNT_EN only)
module stream_demux12 #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             sel,
    output logic [DW-1:0]    m0_data,
    output logic             m0_valid,
    output logic             m0_last,
    input  logic             m0_ready,
    output logic [DW-1:0]    m1_data,
    output logic             m1_valid,
    output logic             m1_last,
    input  logic             m1_ready
`ifdef DEMUX_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT0 = 2'd1,
        ST_PKT1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            target;
    logic            accept;
    logic            load0, load1;

    logic [DW-1:0]   m0_data_q, m1_data_q;
    logic            m0_valid_q, m1_valid_q;
    logic            m0_last_q, m1_last_q;

    // Destination is latched by the FSM state once a multi-beat packet opens,
    // so sel only matters while no packet is open.
    always_comb begin
        target = sel;
        case (state_q)
            ST_PKT0: target = 1'b0;
            ST_PKT1: target = 1'b1;
            default: target = sel;
        endcase
    end

    // Ready depends only on the targeted register having room (or draining
    // this cycle); the other output never back-pressures the input.
    assign s_ready = target ? (~m1_valid_q | m1_ready) : (~m0_valid_q | m0_ready);
    assign accept  = s_valid & s_ready;
    assign load0   = accept & ~target;
    assign load1   = accept &  target;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (!s_last) begin
                        state_d = sel ? ST_PKT1 : ST_PKT0;
                    end
                end
                ST_PKT0, ST_PKT1: begin
                    if (s_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register 0: a load wins over a drain so a drain+reload keeps
    // valid high; data/last only change on a load, which keeps them stable
    // while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_data_q  <= '0;
            m0_last_q  <= 1'b0;
            m0_valid_q <= 1'b0;
        end else if (load0) begin
            m0_data_q  <= s_data;
            m0_last_q  <= s_last;
            m0_valid_q <= 1'b1;
        end else if (m0_valid_q && m0_ready) begin
            m0_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m1_data_q  <= '0;
            m1_last_q  <= 1'b0;
            m1_valid_q <= 1'b0;
        end else if (load1) begin
            m1_data_q  <= s_data;
            m1_last_q  <= s_last;
            m1_valid_q <= 1'b1;
        end else if (m1_valid_q && m1_ready) begin
            m1_valid_q <= 1'b0;
        end
    end

    assign m0_data  = m0_data_q;
    assign m0_valid = m0_valid_q;
    assign m0_last  = m0_last_q;
    assign m1_data  = m1_data_q;
    assign m1_valid = m1_valid_q;
    assign m1_last  = m1_last_q;

`ifdef DEMUX_PKT_CNT_EN
    logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

    // A packet is counted when its last beat is accepted; natural wrap.
    always_comb begin
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        if (load0 && s_last) begin
            pkt_cnt0_d = pkt_cnt0_q + 1'b1;
        end
        if (load1 && s_last) begin
            pkt_cnt1_d = pkt_cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule
